// File: rtl/aes_text_in_wddl.sv
// WDDL plaintext launcher: drives a complementary rail pair for one LOAD cycle, spacer otherwise.
// Optional macro AES_WDDL_PRECHARGE_EN inserts a guaranteed spacer (PRE) cycle before each LOAD.
module aes_text_in_wddl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic         ready,
  output logic         ld_r,
  output logic [127:0] text_in_r,
  output logic [127:0] text_in_r_n,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StIdle = 2'd0, StPre = 2'd1, StLoad = 2'd2, StRun = 2'd3} state_e;

`ifdef AES_WDDL_PRECHARGE_EN
  localparam state_e StLaunch = StPre;
`else
  localparam state_e StLaunch = StLoad;
`endif

  localparam logic [3:0] CntLast = 4'(NR - 1);

  state_e       state_q, state_d;
  logic [127:0] work_q, work_d;
  logic [127:0] pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         accept, last_run;

  logic         ld_r_q, ld_r_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] rail_t_q, rail_t_d;
  logic [127:0] rail_f_q, rail_f_d;

  assign ready    = !pend_vld_q;
  assign accept   = ld && !pend_vld_q;
  assign last_run = (state_q == StRun) && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      work_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      ld_r_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rail_t_q   <= '0;
      rail_f_q   <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      ld_r_q     <= ld_r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rail_t_q   <= rail_t_d;
      rail_f_q   <= rail_f_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;

    // New data bypasses the buffer only when the launcher can take it straight away.
    if (accept) begin
      if (state_q == StIdle || last_run) begin
        work_d = text_in;
      end else begin
        pend_d     = text_in;
        pend_vld_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StLaunch;
      end
`ifdef AES_WDDL_PRECHARGE_EN
      StPre: begin
        state_d = StLoad;
      end
`endif
      StLoad: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + 4'd1;
        if (last_run) begin
          if (pend_vld_q) begin
            work_d     = pend_q;
            pend_vld_d = 1'b0;
            state_d    = StLaunch;
          end else if (accept) begin
            state_d = StLaunch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from next-state so the rails switch cleanly from flops.
  always_comb begin
    ld_r_d   = (state_d == StLoad);
    rail_t_d = ld_r_d ? work_d : '0;
    rail_f_d = ld_r_d ? ~work_d : '0;
    busy_d   = (state_d != StIdle);
    done_d   = last_run;
  end

  assign ld_r        = ld_r_q;
  assign text_in_r   = rail_t_q;
  assign text_in_r_n = rail_f_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_aes_text_in_wddl.sv
// Scoreboard bench for aes_text_in_wddl: expected launches/done pulses are queued by the stimulus
// and popped by per-DUT monitors. Honours AES_WDDL_PRECHARGE_EN for the extra spacer cycle.
module tb_aes_text_in_wddl;

`ifdef AES_WDDL_PRECHARGE_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } ld_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ld, ld1;
  logic [127:0] text_in, text_in1;
  logic         ready, ld_r, busy, done;
  logic [127:0] text_in_r, text_in_r_n;
  logic         ready1, ld_r1, busy1, done1;
  logic [127:0] text_in_r1, text_in_r_n1;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  dn1_seen = 0;
  bit  mon_en = 1'b0;
  int  c, l, p;

  ld_t exp_ld[$];
  int  exp_dn[$];
  ld_t exp_ld1[$];
  int  exp_dn1[$];

  aes_text_in_wddl #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .text_in(text_in), .ready(ready), .ld_r(ld_r),
    .text_in_r(text_in_r), .text_in_r_n(text_in_r_n), .busy(busy), .done(done)
  );

  aes_text_in_wddl #(.NR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ld(ld1), .text_in(text_in1), .ready(ready1), .ld_r(ld_r1),
    .text_in_r(text_in_r1), .text_in_r_n(text_in_r_n1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic send1(input logic [127:0] d);
    bit ok;
    ok = 1'b0;
    ld1 = 1'b1;
    text_in1 = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = ready1;
      step();
    end
    if (!ok) chk("send1_timeout", 0, 1);
  endtask

  // Monitor for the NR=10 instance.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rail_excl", text_in_r & text_in_r_n, '0);
      if (ld_r) begin
        if (exp_ld.size() == 0) begin
          chk("unexp_load", text_in_r, '0);
          chk("unexp_load_flag", 1, 0);
        end else begin
          ld_t e;
          e = exp_ld.pop_front();
          chk("load_cyc", cyc, e.cyc);
          chk("rail_t", text_in_r, e.data);
          chk("rail_f", text_in_r_n, ~e.data);
        end
      end else begin
        chk("spacer", text_in_r | text_in_r_n, '0);
      end
      if (done) begin
        if (exp_dn.size() == 0) chk("unexp_done", 1, 0);
        else chk("done_cyc", cyc, exp_dn.pop_front());
      end
    end
  end

  // Monitor for the NR=1 instance.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rail_excl1", text_in_r1 & text_in_r_n1, '0);
      if (ld_r1) begin
        if (exp_ld1.size() == 0) begin
          chk("unexp_load1", 1, 0);
        end else begin
          ld_t e;
          e = exp_ld1.pop_front();
          chk("load_cyc1", cyc, e.cyc);
          chk("rail_t1", text_in_r1, e.data);
          chk("rail_f1", text_in_r_n1, ~e.data);
        end
      end else begin
        chk("spacer1", text_in_r1 | text_in_r_n1, '0);
      end
      if (done1) begin
        dn1_seen++;
        if (exp_dn1.size() == 0) chk("unexp_done1", 1, 0);
        else chk("done_cyc1", cyc, exp_dn1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    ld = 1'b0;
    ld1 = 1'b0;
    text_in = '0;
    text_in1 = '0;
    repeat (3) step();
    chk("rst_ld_r", ld_r, 0);
    chk("rst_rail_t", text_in_r, '0);
    chk("rst_rail_f", text_in_r_n, '0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 1);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    // Single block from IDLE.
    c = cyc;
    l = c + 1 + PRE;
    ld = 1'b1;
    text_in = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    exp_ld.push_back('{data: text_in, cyc: l});
    exp_dn.push_back(l + 11);
    step();
    ld = 1'b0;
    chk("t1_busy", busy, 1);
    wait_cyc(l);
    chk("t1_rail_f_const", text_in_r_n, 128'hFFEEDDCC_BBAA9988_77665544_33221100);
    wait_cyc(l + 11);
    chk("t1_busy_end", busy, 0);
    chk("t1_ready_end", ready, 1);
    step();

    // Queue B during RUN; C is ignored while the buffer is full.
    c = cyc;
    l = c + 1 + PRE;
    ld = 1'b1;
    text_in = 128'hA5A5A5A5_00000000_FFFFFFFF_12345678;
    exp_ld.push_back('{data: text_in, cyc: l});
    exp_dn.push_back(l + 11);
    step();
    ld = 1'b0;
    wait_cyc(l + 3);
    ld = 1'b1;
    text_in = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    exp_ld.push_back('{data: text_in, cyc: l + 11 + PRE});
    exp_dn.push_back(l + 22 + PRE);
    step();
    chk("t2_ready_low", ready, 0);
    text_in = 128'hC0C0C0C0_C0C0C0C0_C0C0C0C0_C0C0C0C0;
    step();
    step();
    ld = 1'b0;
    wait_cyc(l + 11);
    chk("t2_ready_back", ready, 1);
    wait_cyc(l + 25);

    // Load on the last RUN cycle with an empty buffer.
    c = cyc;
    l = c + 1 + PRE;
    ld = 1'b1;
    text_in = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    exp_ld.push_back('{data: text_in, cyc: l});
    exp_dn.push_back(l + 11);
    step();
    ld = 1'b0;
    wait_cyc(l + 10);
    chk("t3_ready_last", ready, 1);
    ld = 1'b1;
    text_in = 128'hEEEEEEEE_11111111_EEEEEEEE_11111111;
    exp_ld.push_back('{data: text_in, cyc: l + 11 + PRE});
    exp_dn.push_back(l + 22 + PRE);
    step();
    ld = 1'b0;
    chk("t3_ready_after", ready, 1);
    chk("t3_busy_no_idle", busy, 1);
    wait_cyc(l + 25);

    // Reset at RUN cnt=4 with a pending block: both blocks discarded.
    c = cyc;
    l = c + 1 + PRE;
    ld = 1'b1;
    text_in = 128'hF0F0F0F0_0F0F0F0F_F0F0F0F0_0F0F0F0F;
    exp_ld.push_back('{data: text_in, cyc: l});
    step();
    ld = 1'b0;
    wait_cyc(l + 2);
    ld = 1'b1;
    text_in = 128'h99999999_88888888_77777777_66666666;
    step();
    ld = 1'b0;
    chk("t4_ready_pend", ready, 0);
    wait_cyc(l + 5);
    rst_n = 1'b0;
    exp_dn.delete();
    step();
    rst_n = 1'b1;
    chk("t4_ld_r", ld_r, 0);
    chk("t4_rail_t", text_in_r, '0);
    chk("t4_rail_f", text_in_r_n, '0);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_ready", ready, 1);
    wait_cyc(l + 30);

    // NR=1, three blocks offered back to back.
    c = cyc;
    l = c + 1 + PRE;
    p = 2 + PRE;
    exp_ld1.push_back('{data: 128'h11111111_22222222_33333333_44444444, cyc: l});
    exp_ld1.push_back('{data: 128'h55555555_66666666_77777777_88888888, cyc: l + p});
    exp_ld1.push_back('{data: 128'h0123ABCD_4567EF01_89AB2345_CDEF6789, cyc: l + 2 * p});
    exp_dn1.push_back(l + 2);
    exp_dn1.push_back(l + p + 2);
    exp_dn1.push_back(l + 2 * p + 2);
    send1(128'h11111111_22222222_33333333_44444444);
    send1(128'h55555555_66666666_77777777_88888888);
    send1(128'h0123ABCD_4567EF01_89AB2345_CDEF6789);
    ld1 = 1'b0;
    wait_cyc(l + 2 * p + 8);

    chk("end_ld_q", exp_ld.size(), 0);
    chk("end_dn_q", exp_dn.size(), 0);
    chk("end_ld1_q", exp_ld1.size(), 0);
    chk("end_dn1_q", exp_dn1.size(), 0);
    chk("nr1_done_count", dn1_seen, 3);
    chk("end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
